// File: rtl/crc_serial_gen.sv
// +--------------------------------------------------------------------------+
// | crc_serial_gen : serial Galois-LFSR CRC generator, LSB-first streamed out  |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module crc_serial_gen #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] POLY    = 8'hC4,
   parameter logic [WIDTH-1:0] SEED    = 8'hFF,
   parameter logic [WIDTH-1:0] XOR_OUT = 8'h00
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLEAR,
   input  logic DATA,
   input  logic ACTIVE,
   input  logic READY,
   output logic CRC,
   output logic Valid,
   output logic DONE,
   output logic OVERRUN
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             crc_q, crc_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] final_crc;

   // Right-shift Galois step: feedback enters every tap and the top bit.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur,
                                                  input logic             din);
      logic             fb;
      logic [WIDTH-1:0] nxt;
      nxt = '0;
      fb  = cur[0] ^ din;
      for (int i = 0; i < WIDTH - 1; i++) begin
         nxt[i] = cur[i+1] ^ (POLY[i] & fb);
      end
      nxt[WIDTH-1] = fb;
      return nxt;
   endfunction

   assign lfsr_next = lfsr_step(lfsr_q, DATA);
   assign final_crc = lfsr_q ^ XOR_OUT;

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      crc_d     = crc_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;

      if (CLEAR) begin
         state_d   = ST_IDLE;
         lfsr_d    = SEED;
         sr_d      = '0;
         cnt_d     = '0;
         crc_d     = 1'b0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ACTIVE) begin
                  lfsr_d  = lfsr_next;
                  state_d = ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (ACTIVE) begin
                  lfsr_d = lfsr_next;
               end else begin
                  crc_d   = final_crc[0];
                  sr_d    = final_crc >> 1;
                  cnt_d   = CNT_ONE;
                  valid_d = 1'b1;
                  state_d = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Message bits arriving while the result drains are dropped.
               if (ACTIVE) begin
                  overrun_d = 1'b1;
               end
               if (READY) begin
                  if (cnt_q < CNT_LAST) begin
                     crc_d = sr_q[0];
                     sr_d  = sr_q >> 1;
                     cnt_d = cnt_q + CNT_ONE;
                  end else begin
                     crc_d   = 1'b0;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     cnt_d   = '0;
                     lfsr_d  = SEED;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= SEED;
         sr_q      <= '0;
         cnt_q     <= '0;
         crc_q     <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         crc_q     <= crc_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign CRC     = crc_q;
   assign Valid   = valid_q;
   assign DONE    = done_q;
   assign OVERRUN = overrun_q;

endmodule

`default_nettype wire
